mc_control_fsm: RTL and testbench

Multi-cycle control path for the RV32I core. It replaces the single-cycle decoder with a sequencing FSM: FETCH, DECODE, EXEC, MEM, WB, TRAP. Instruction and data memories use a req/ack handshake with an optional timeout. The block drives the same datapath control encodings as the single-cycle control path, plus sequencing strobes and a retired-instruction counter.

---
 rtl/mc_control_fsm.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control path: sequences FETCH/DECODE/EXEC/MEM/WB/TRAP,
// registers decoded datapath controls and counts retired instructions.
module mc_control_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             ir_wr,
    output logic             dmem_req,
    output logic             wr_en,
    output logic             rd_en,
    output logic             reg_wr,
    output logic             pc_wr,
    output logic             pc_src,
    output logic             sel_A,
    output logic             sel_B,
    output logic [3:0]       alu_op,
    output logic [2:0]       imm_gen,
    output logic [2:0]       br_type,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_L     = 7'd3;
    localparam logic [6:0] OP_S     = 7'd35;
    localparam logic [6:0] OP_B     = 7'd99;
    localparam logic [6:0] OP_AUIPC = 7'd23;
    localparam logic [6:0] OP_LUI   = 7'd55;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_JALR  = 7'd103;

    localparam bit             TO_EN     = (TIMEOUT != 0);
    localparam int             TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST  = TO_LAST_I[TO_W-1:0];

    // R-type ALU select from {instr[30], instr[25], funct3}; unknown encodings fall back to add.
    function automatic logic [3:0] r_alu_op(input logic b30, input logic b25, input logic [2:0] f3);
        logic [3:0] op;
        case ({b30, b25, f3})
            5'b00_000: op = 4'd0;
            5'b10_000: op = 4'd1;
            5'b00_001: op = 4'd2;
            5'b00_101: op = 4'd3;
            5'b10_101: op = 4'd4;
            5'b00_111: op = 4'd5;
            5'b00_110: op = 4'd6;
            5'b00_100: op = 4'd7;
            5'b00_011: op = 4'd8;
            5'b00_010: op = 4'd9;
            default:   op = 4'd0;
        endcase
        return op;
    endfunction

    // I-type ALU select; instr[30] only distinguishes srai from srli.
    function automatic logic [3:0] i_alu_op(input logic b30, input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = 4'd0;
            3'b001:  op = 4'd2;
            3'b101:  op = b30 ? 4'd4 : 4'd3;
            3'b111:  op = 4'd5;
            3'b110:  op = 4'd6;
            3'b100:  op = 4'd7;
            3'b011:  op = 4'd8;
            3'b010:  op = 4'd9;
            default: op = 4'd0;
        endcase
        return op;
    endfunction

    state_t            state_q, state_nx;
    logic [1:0]        cause_q, cause_nx;
    logic [TO_W-1:0]   wait_q, wait_nx;
    logic [CNT_W-1:0]  instret_q;
    logic              ld_ctrl, retire;

    logic [3:0] alu_op_q;
    logic [2:0] imm_gen_q, br_type_q;
    logic [1:0] wb_sel_q;
    logic       sel_a_q, sel_b_q;
    logic       is_load_q, is_store_q, is_branch_q, is_jump_q, reg_wr_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       d_legal, d_sel_a, d_sel_b, d_load, d_store, d_branch, d_jump, d_reg_wr;
    logic [3:0] d_alu_op;
    logic [2:0] d_imm_gen, d_br_type;
    logic [1:0] d_wb_sel;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:26], instr[24:15], instr[11:7]};

    always_comb begin
        d_legal   = 1'b1;
        d_alu_op  = 4'd0;
        d_imm_gen = 3'd0;
        d_br_type = 3'd2;
        d_sel_a   = 1'b0;
        d_sel_b   = 1'b0;
        d_wb_sel  = 2'd0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_reg_wr  = 1'b0;
        case (opcode)
            OP_R: begin
                d_sel_a  = 1'b1;
                d_sel_b  = 1'b1;
                d_wb_sel = 2'd1;
                d_reg_wr = 1'b1;
                d_alu_op = r_alu_op(instr[30], instr[25], funct3);
            end
            OP_I: begin
                d_sel_a  = 1'b1;
                d_wb_sel = 2'd1;
                d_reg_wr = 1'b1;
                d_alu_op = i_alu_op(instr[30], funct3);
            end
            OP_L: begin
                d_sel_a  = 1'b1;
                d_load   = 1'b1;
                d_reg_wr = 1'b1;
            end
            OP_S: begin
                d_imm_gen = 3'd1;
                d_sel_a   = 1'b1;
                d_store   = 1'b1;
            end
            OP_B: begin
                d_imm_gen = 3'd2;
                d_br_type = funct3;
                d_branch  = 1'b1;
            end
            OP_AUIPC: begin
                d_imm_gen = 3'd3;
                d_wb_sel  = 2'd1;
                d_reg_wr  = 1'b1;
            end
            OP_LUI: begin
                d_imm_gen = 3'd3;
                d_sel_a   = 1'b1;
                d_wb_sel  = 2'd1;
                d_alu_op  = 4'd10;
                d_reg_wr  = 1'b1;
            end
            OP_JAL: begin
                d_imm_gen = 3'd4;
                d_wb_sel  = 2'd2;
                d_br_type = 3'd3;
                d_jump    = 1'b1;
                d_reg_wr  = 1'b1;
            end
            OP_JALR: begin
                d_sel_a   = 1'b1;
                d_wb_sel  = 2'd2;
                d_br_type = 3'd3;
                d_jump    = 1'b1;
                d_reg_wr  = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state_q;
        cause_nx = cause_q;
        wait_nx  = wait_q;
        ld_ctrl  = 1'b0;
        retire   = 1'b0;
        imem_req = 1'b0;
        ir_wr    = 1'b0;
        dmem_req = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        reg_wr   = 1'b0;
        pc_wr    = 1'b0;
        pc_src   = 1'b0;
        trap     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_wr    = 1'b1;
                    state_nx = S_DECODE;
                    wait_nx  = '0;
                end else if (TO_EN && wait_q == TO_LAST) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'd1;
                end else begin
                    wait_nx = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (d_legal) begin
                    ld_ctrl  = 1'b1;
                    state_nx = S_EXEC;
                end else begin
                    state_nx = S_TRAP;
                    cause_nx = 2'd2;
                end
            end
            S_EXEC: state_nx = (is_load_q || is_store_q) ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                wr_en    = is_store_q;
                rd_en    = is_load_q;
                // An ack on the final timeout cycle still completes the access.
                if (dmem_ack) begin
                    state_nx = S_WB;
                    wait_nx  = '0;
                end else if (TO_EN && wait_q == TO_LAST) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'd3;
                end else begin
                    wait_nx = wait_q + 1'b1;
                end
            end
            S_WB: begin
                pc_wr    = 1'b1;
                reg_wr   = reg_wr_q;
                pc_src   = is_jump_q || (is_branch_q && br_taken);
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_nx = S_FETCH;
        endcase
        // No memory requests or writes are issued while reset is held.
        if (!rst) begin
            imem_req = 1'b0;
            ir_wr    = 1'b0;
            dmem_req = 1'b0;
            wr_en    = 1'b0;
            rd_en    = 1'b0;
            reg_wr   = 1'b0;
            pc_wr    = 1'b0;
            pc_src   = 1'b0;
            trap     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            cause_q     <= 2'd0;
            wait_q      <= '0;
            instret_q   <= '0;
            alu_op_q    <= 4'd0;
            imm_gen_q   <= 3'd0;
            br_type_q   <= 3'd2;
            sel_a_q     <= 1'b0;
            sel_b_q     <= 1'b0;
            wb_sel_q    <= 2'd0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
            is_jump_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
        end else begin
            state_q <= state_nx;
            cause_q <= cause_nx;
            wait_q  <= wait_nx;
            if (retire) instret_q <= instret_q + 1'b1;
            if (ld_ctrl) begin
                alu_op_q    <= d_alu_op;
                imm_gen_q   <= d_imm_gen;
                br_type_q   <= d_br_type;
                sel_a_q     <= d_sel_a;
                sel_b_q     <= d_sel_b;
                wb_sel_q    <= d_wb_sel;
                is_load_q   <= d_load;
                is_store_q  <= d_store;
                is_branch_q <= d_branch;
                is_jump_q   <= d_jump;
                reg_wr_q    <= d_reg_wr;
            end
        end
    end

    assign state   = state_q;
    assign cause   = cause_q;
    assign instret = instret_q;
    assign alu_op  = alu_op_q;
    assign imm_gen = imm_gen_q;
    assign br_type = br_type_q;
    assign sel_A   = sel_a_q;
    assign sel_B   = sel_b_q;
    assign wb_sel  = wb_sel_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: instruction sequencing, handshakes,
// timeouts, illegal opcode and reset from mid-access.
module tb_mc_control_fsm;
    localparam int CNT_W = 32;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic             clk = 1'b0;
    logic             rst, imem_ack, dmem_ack, br_taken;
    logic [31:0]      instr;
    logic             imem_req, ir_wr, dmem_req, wr_en, rd_en, reg_wr, pc_wr, pc_src;
    logic             sel_A, sel_B, trap;
    logic [3:0]       alu_op;
    logic [2:0]       imm_gen, br_type, state;
    logic [1:0]       wb_sel, cause;
    logic [CNT_W-1:0] instret;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.TIMEOUT(16), .CNT_W(CNT_W), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .br_taken(br_taken), .imem_req(imem_req), .ir_wr(ir_wr), .dmem_req(dmem_req),
        .wr_en(wr_en), .rd_en(rd_en), .reg_wr(reg_wr), .pc_wr(pc_wr), .pc_src(pc_src),
        .sel_A(sel_A), .sel_B(sel_B), .alu_op(alu_op), .imm_gen(imm_gen), .br_type(br_type),
        .wb_sel(wb_sel), .state(state), .trap(trap), .cause(cause), .instret(instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Fetch with an immediate ack, then advance through DECODE into EXEC.
    task automatic fetch_decode(input logic [31:0] ins);
        instr    = ins;
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        cyc();
        chk("exec_state", 32'(state), 32'd2);
    endtask

    initial begin
        rst = 1'b0; instr = 32'h0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
        cyc();
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_br_type", 32'(br_type), 32'd2);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_ctrl", {26'd0, imm_gen, wb_sel, sel_A}, 32'd0);
        chk("rst_sel_B", 32'(sel_B), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);

        // add: F, D, E, W
        rst = 1'b1; instr = I_ADD; imem_ack = 1'b1;
        #1;
        chk("add_imem_req", 32'(imem_req), 32'd1);
        chk("add_ir_wr", 32'(ir_wr), 32'd1);
        cyc();
        imem_ack = 1'b0;
        #1;
        chk("add_decode", 32'(state), 32'd1);
        chk("add_ir_wr_off", 32'(ir_wr), 32'd0);
        cyc();
        chk("add_exec", 32'(state), 32'd2);
        cyc();
        chk("add_wb_state", 32'(state), 32'd4);
        chk("add_alu_op", 32'(alu_op), 32'd0);
        chk("add_sel", {30'd0, sel_A, sel_B}, 32'd3);
        chk("add_wb_sel", 32'(wb_sel), 32'd1);
        chk("add_reg_wr", 32'(reg_wr), 32'd1);
        chk("add_pc_wr", 32'(pc_wr), 32'd1);
        chk("add_pc_src", 32'(pc_src), 32'd0);
        chk("add_instret_wb", instret, 32'd0);
        cyc();
        chk("add_fetch", 32'(state), 32'd0);
        chk("add_instret", instret, 32'd1);

        // sub then srai
        fetch_decode(I_SUB);
        chk("sub_alu_op", 32'(alu_op), 32'd1);
        cyc(); cyc();
        fetch_decode(I_SRAI);
        chk("srai_alu_op", 32'(alu_op), 32'd4);
        chk("srai_sel_B", 32'(sel_B), 32'd0);
        chk("srai_imm_gen", 32'(imm_gen), 32'd0);
        cyc(); cyc();
        chk("srai_instret", instret, 32'd3);

        // lw with ack on the 4th MEM cycle: 8 cycles total
        fetch_decode(I_LW);
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            #1;
            chk("lw_mem_state", 32'(state), 32'd3);
            chk("lw_rd_wr", {30'd0, rd_en, wr_en}, 32'd2);
            chk("lw_dmem_req", 32'(dmem_req), 32'd1);
            cyc();
        end
        dmem_ack = 1'b0;
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_sel", 32'(wb_sel), 32'd0);
        chk("lw_reg_wr", 32'(reg_wr), 32'd1);
        chk("lw_rd_en_off", 32'(rd_en), 32'd0);
        cyc();
        chk("lw_fetch", 32'(state), 32'd0);
        chk("lw_instret", instret, 32'd4);

        // beq taken / not taken
        fetch_decode(I_BEQ);
        chk("beq_br_type", 32'(br_type), 32'd0);
        chk("beq_imm_gen", 32'(imm_gen), 32'd2);
        chk("beq_sel_A", 32'(sel_A), 32'd0);
        cyc();
        br_taken = 1'b1;
        #1;
        chk("beq_t_pc_src", 32'(pc_src), 32'd1);
        chk("beq_t_reg_wr", 32'(reg_wr), 32'd0);
        cyc();
        br_taken = 1'b0;
        fetch_decode(I_BEQ);
        cyc();
        chk("beq_nt_pc_src", 32'(pc_src), 32'd0);
        cyc();
        chk("beq_instret", instret, 32'd6);

        // imem ack arriving on the 16th wait cycle
        instr = I_ADD;
        for (int i = 0; i < 15; i++) begin
            chk("late_imem_req", 32'(imem_req), 32'd1);
            cyc();
        end
        imem_ack = 1'b1;
        #1;
        chk("late_ir_wr", 32'(ir_wr), 32'd1);
        cyc();
        imem_ack = 1'b0;
        chk("late_decode", 32'(state), 32'd1);
        chk("late_no_trap", 32'(trap), 32'd0);
        cyc(); cyc(); cyc();
        chk("late_instret", instret, 32'd7);

        // imem timeout
        for (int i = 0; i < 16; i++) begin
            chk("to_fetch_state", 32'(state), 32'd0);
            chk("to_imem_req", 32'(imem_req), 32'd1);
            cyc();
        end
        chk("to_state", 32'(state), 32'd5);
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(cause), 32'd1);
        chk("to_imem_req_off", 32'(imem_req), 32'd0);
        cyc();
        chk("to_stays", 32'(state), 32'd5);

        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("trap_rst_state", 32'(state), 32'd0);
        chk("trap_rst_cause", 32'(cause), 32'd0);
        chk("trap_rst_instret", instret, 32'd0);

        // illegal opcode
        instr = I_BAD; imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        chk("bad_decode", 32'(state), 32'd1);
        cyc();
        chk("bad_state", 32'(state), 32'd5);
        chk("bad_cause", 32'(cause), 32'd2);
        chk("bad_trap", 32'(trap), 32'd1);

        rst = 1'b0;
        cyc();
        rst = 1'b1;

        // store with dmem timeout
        fetch_decode(I_SW);
        chk("sw_imm_gen", 32'(imm_gen), 32'd1);
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk("sw_rd_wr", {30'd0, rd_en, wr_en}, 32'd1);
            chk("sw_dmem_req", 32'(dmem_req), 32'd1);
            cyc();
        end
        chk("sw_to_state", 32'(state), 32'd5);
        chk("sw_to_cause", 32'(cause), 32'd3);
        chk("sw_to_wr_en", 32'(wr_en), 32'd0);

        rst = 1'b0;
        cyc();
        rst = 1'b1;

        // reset asserted during a MEM wait
        fetch_decode(I_ADD);
        cyc(); cyc();
        chk("pre_instret", instret, 32'd1);
        fetch_decode(I_LW);
        cyc(); cyc();
        chk("mid_mem_state", 32'(state), 32'd3);
        rst = 1'b0;
        cyc();
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_instret", instret, 32'd0);
        chk("mid_rst_strobes",
            {23'd0, imem_req, ir_wr, dmem_req, wr_en, rd_en, reg_wr, pc_wr, pc_src, trap}, 32'd0);
        chk("mid_rst_br_type", 32'(br_type), 32'd2);
        rst = 1'b1;
        #1;
        chk("post_rst_imem_req", 32'(imem_req), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
